// File: rtl/ins_ram_pkg.sv
// Shared constants and types for the instruction memory.
//   INS_W / ADDR_W : instruction and word-address widths
//   NOP_INS        : word returned for out-of-range fetches
//   CNT_W          : width of the wait counter (LATENCY <= 15)
//   ram_state_e    : fetch FSM states
package ins_ram_pkg;

  localparam int unsigned INS_W  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ram_state_e;

  // Full-width comparison, no aliasing of high address bits.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a,
                                         input int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/ins_ram.sv
// Word-addressed instruction memory with a fixed fetch latency.
//   clk, rst            : clock, synchronous active-high reset
//   en_ram_in, addr     : fetch request and word address
//   load_en/addr/data   : preload write port (active in any state, ignores rst)
//   ins                 : fetched word, held until the next completion
//   en_ram_out          : one-cycle completion strobe
//   busy                : a fetch is outstanding
//   addr_err            : completed fetch was out of range (with en_ram_out)
module ins_ram
  import ins_ram_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INS_W-1:0]  load_data,
  output logic [INS_W-1:0]  ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic              addr_err
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ins_ram: LATENCY must be in 1..15");
  end

  logic [INS_W-1:0] mem [DEPTH];

  ram_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [INS_W-1:0]  data_q,  data_d;
  logic [INS_W-1:0]  ins_q,   ins_d;
  logic              out_q,   out_d;
  logic              busy_q,  busy_d;
  logic              err_q,   err_d;

  logic              accept;
  logic              fetch_ok;
  logic [INS_W-1:0]  rd_word;

  // Read is taken from the array before any same-edge load lands, so a
  // colliding load is only seen by later fetches.
  always_comb begin
    fetch_ok = addr_in_range(addr, DEPTH);
    rd_word  = fetch_ok ? mem[addr[IDX_W-1:0]] : NOP_INS;
    // The completion cycle is already ST_IDLE, which gives back-to-back accepts.
    accept   = en_ram_in && (state_q == ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ins_d   = ins_q;
    busy_d  = busy_q;
    out_d   = 1'b0;
    err_d   = 1'b0;

    if (state_q == ST_WAIT) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ins_d   = data_q;
        out_d   = 1'b1;
        err_d   = !addr_in_range(addr_q, DEPTH);
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (accept) begin
      addr_d = addr;
      data_d = rd_word;
      if (LATENCY == 1) begin
        // Acceptance edge is also the completion edge.
        ins_d  = rd_word;
        out_d  = 1'b1;
        err_d  = !fetch_ok;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= NOP_INS;
      ins_q   <= NOP_INS;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ins_q   <= ins_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside reset so preloaded code survives it.
  always_ff @(posedge clk) begin
    if (load_en && addr_in_range(load_addr, DEPTH)) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  assign ins        = ins_q;
  assign en_ram_out = out_q;
  assign busy       = busy_q;
  assign addr_err   = err_q;

endmodule
